// File: rtl/exe_stage.sv
// Execute stage: operand-2 shifter, single-cycle ALU with NZCV flags, branch
// target adder and a fixed-latency 32-step shift-add multiplier that stalls.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        S,
  input  logic        I,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [11:0] shiftOperand,
  input  logic [23:0] Imm24,
  output logic [31:0] ALU_Res,
  output logic [31:0] Br_Addr,
  output logic [3:0]  status,
  output logic        stall
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MUL = 4'b1010
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  cmd_e        cmd;
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [3:0]  status_q, status_d;

  logic [31:0] val2;
  logic [31:0] add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        alu_c, alu_v, alu_upd;

  assign cmd     = cmd_e'(EXE_CMD);
  assign status  = status_q;
  assign Br_Addr = PC + {{6{Imm24[23]}}, Imm24, 2'b00};

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  always_comb begin
    val2 = '0;
    if (I) begin
      val2 = ror32({24'b0, shiftOperand[7:0]}, {shiftOperand[11:8], 1'b0});
    end else if (MEM_R_EN || MEM_W_EN) begin
      val2 = {20'b0, shiftOperand};
    end else begin
      case (shiftOperand[6:5])
        2'b00:   val2 = Val_Rm << shiftOperand[11:7];
        2'b01:   val2 = Val_Rm >> shiftOperand[11:7];
        2'b10:   val2 = $signed(Val_Rm) >>> shiftOperand[11:7];
        default: val2 = ror32(Val_Rm, shiftOperand[11:7]);
      endcase
    end
  end

  // Subtraction reuses the adder as Rn + ~Val2 + cin, so C is the no-borrow flag.
  always_comb begin
    add_b   = ((cmd == CMD_SUB) || (cmd == CMD_SBC)) ? ~val2 : val2;
    add_cin = 1'b0;
    case (cmd)
      CMD_ADC, CMD_SBC: add_cin = status_q[1];
      CMD_SUB:          add_cin = 1'b1;
      default:          add_cin = 1'b0;
    endcase
    sum = {1'b0, Val_Rn} + {1'b0, add_b} + {32'b0, add_cin};
  end

  always_comb begin
    alu_res = '0;
    alu_c   = status_q[1];
    alu_v   = status_q[0];
    alu_upd = 1'b0;
    case (cmd)
      CMD_MOV: begin alu_res = val2;           alu_upd = 1'b1; end
      CMD_MVN: begin alu_res = ~val2;          alu_upd = 1'b1; end
      CMD_AND: begin alu_res = Val_Rn & val2;  alu_upd = 1'b1; end
      CMD_ORR: begin alu_res = Val_Rn | val2;  alu_upd = 1'b1; end
      CMD_EOR: begin alu_res = Val_Rn ^ val2;  alu_upd = 1'b1; end
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (Val_Rn[31] == add_b[31]) && (sum[31] != Val_Rn[31]);
        alu_upd = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    status_d = status_q;
    stall    = 1'b0;
    ALU_Res  = alu_res;
    case (state_q)
      ST_IDLE: begin
        if (cmd == CMD_MUL) begin
          stall    = 1'b1;
          ALU_Res  = '0;
          mcand_d  = Val_Rn;
          mplier_d = val2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end else if (S && alu_upd) begin
          status_d = {alu_res[31], (alu_res == '0), alu_c, alu_v};
        end
      end
      ST_BUSY: begin
        stall   = 1'b1;
        ALU_Res = '0;
        if (mplier_q[cnt_q]) acc_d = acc_q + (mcand_q << cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_DONE;
      end
      ST_DONE: begin
        ALU_Res = acc_q;
        if (S) status_d = {acc_q[31], (acc_q == '0), status_q[1:0]};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic        MEM_R_EN, MEM_W_EN, S, I;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic [11:0] shiftOperand;
  logic [23:0] Imm24;
  logic [31:0] ALU_Res, Br_Addr;
  logic [3:0]  status;
  logic        stall;

  int passes = 0;
  int total  = 0;
  int cycles;

  exe_stage dut (
    .clk          (clk),
    .rst          (rst),
    .EXE_CMD      (EXE_CMD),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .S            (S),
    .I            (I),
    .PC           (PC),
    .Val_Rn       (Val_Rn),
    .Val_Rm       (Val_Rm),
    .shiftOperand (shiftOperand),
    .Imm24        (Imm24),
    .ALU_Res      (ALU_Res),
    .Br_Addr      (Br_Addr),
    .status       (status),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic s, input logic i,
                    input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so);
    EXE_CMD = c; S = s; I = i; Val_Rn = rn; Val_Rm = rm; shiftOperand = so;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; EXE_CMD = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; S = 1'b0; I = 1'b0;
    PC = '0; Val_Rn = '0; Val_Rm = '0; shiftOperand = '0; Imm24 = '0;
    tick; tick;
    check("rst_status", {28'b0, status}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_res", ALU_Res, 32'h0);
    rst = 1'b0;

    op(4'b0010, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
    check("add_ovf_res", ALU_Res, 32'h8000_0000);
    tick;
    check("add_ovf_status", {28'b0, status}, 32'h9);

    op(4'b0001, 1'b0, 1'b1, 32'h0, 32'h0, 12'h2FF);
    check("mov_rot", ALU_Res, 32'hF000_000F);
    check("mov_stall", {31'b0, stall}, 32'h0);
    op(4'b1001, 1'b0, 1'b1, 32'h0, 32'h0, 12'h2FF);
    check("mvn_rot", ALU_Res, 32'h0FFF_FFF0);

    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h240);
    check("asr4", ALU_Res, 32'hF800_0000);
    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h0000_000F, 12'h260);
    check("ror4", ALU_Res, 32'hF000_0000);
    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h0000_000F, 12'h200);
    check("lsl4", ALU_Res, 32'h0000_00F0);
    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h220);
    check("lsr4", ALU_Res, 32'h0800_0000);

    MEM_R_EN = 1'b1;
    op(4'b0001, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 12'hABC);
    check("mem_offset", ALU_Res, 32'h0000_0ABC);
    MEM_R_EN = 1'b0;
    tick;
    check("s0_keeps_status", {28'b0, status}, 32'h9);

    op(4'b0100, 1'b0, 1'b1, 32'd5, 32'h0, 12'h005);
    check("sub_s0_res", ALU_Res, 32'h0);
    tick;
    check("sub_s0_status", {28'b0, status}, 32'h9);
    op(4'b0100, 1'b1, 1'b1, 32'd5, 32'h0, 12'h005);
    tick;
    check("sub_s1_status", {28'b0, status}, 32'h6);

    op(4'b0011, 1'b1, 1'b1, 32'd1, 32'h0, 12'h001);
    check("adc_res", ALU_Res, 32'd3);
    tick;
    check("adc_status", {28'b0, status}, 32'h0);
    op(4'b0101, 1'b1, 1'b1, 32'd10, 32'h0, 12'h003);
    check("sbc_res", ALU_Res, 32'd6);
    tick;
    check("sbc_status", {28'b0, status}, 32'h2);

    op(4'b0110, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0, 12'h0FF);
    check("and", ALU_Res, 32'h0000_00F0);
    op(4'b0111, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0, 12'h0FF);
    check("orr", ALU_Res, 32'hF0F0_F0FF);
    op(4'b1000, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0, 12'h0FF);
    check("eor", ALU_Res, 32'hF0F0_F00F);
    op(4'b0110, 1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0, 12'h00F);
    tick;
    check("and_keeps_cv", {28'b0, status}, 32'h6);

    op(4'b1111, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 12'h001);
    check("undef_res", ALU_Res, 32'h0);
    check("undef_stall", {31'b0, stall}, 32'h0);
    tick;
    check("undef_status", {28'b0, status}, 32'h6);

    PC = 32'h0000_0100; Imm24 = 24'hFFFFFF; #1;
    check("br_neg", Br_Addr, 32'h0000_00FC);
    PC = 32'h0000_1000; Imm24 = 24'h000010; #1;
    check("br_pos", Br_Addr, 32'h0000_1040);

    op(4'b1010, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 12'h000);
    check("mul_stall_idle", {31'b0, stall}, 32'h1);
    cycles = 0;
    while (stall && cycles < 40) begin
      cycles++;
      tick;
      if (cycles == 1) begin
        Val_Rn = 32'h55; Val_Rm = 32'h3;
      end
    end
    check("mul_stall_cycles", cycles, 32'd33);
    check("mul_done_stall", {31'b0, stall}, 32'h0);
    check("mul_result", ALU_Res, 32'hFFFF_FFEB);
    tick;
    check("mul_status", {28'b0, status}, 32'hA);
    check("mul_restart", {31'b0, stall}, 32'h1);

    repeat (10) tick;
    rst = 1'b1;
    op(4'b0001, 1'b0, 1'b1, 32'h0, 32'h0, 12'h001);
    tick;
    check("rst_mid_status", {28'b0, status}, 32'h0);
    check("rst_mid_stall", {31'b0, stall}, 32'h0);
    rst = 1'b0;
    tick;
    check("post_rst_idle", {31'b0, stall}, 32'h0);
    check("post_rst_mov", ALU_Res, 32'h1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have the following inputs:
- EXE_CMD input 4: ALU command.
- MEM_R_EN input 1: load flag.
- MEM_W_EN input 1: store flag.
- S input 1: update flags.
- I input 1: immediate operand.
- PC input 32: PC of this instruction.
- Val_Rn input 32: first operand.
- Val_Rm input 32: second register value.
- shiftOperand input 12: operand-2 field.
- Imm24 input 24: branch offset.
REQ-003 SHALL have the following outputs:
- ALU_Res output 32: ALU result.
- Br_Addr output 32: branch target.
- status output 4: {N,Z,C,V} status register.
- stall output 1: hold upstream and pipeline registers.

Function
REQ-004 SHALL decode EXE_CMD as: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010; all other codes give ALU_Res=0 with no flag update.
REQ-005 SHALL form Val2 combinationally:
- I=1: {24'b0,shiftOperand[7:0]} rotated right by 2*shiftOperand[11:8].
- I=0 with MEM_R_EN|MEM_W_EN: zero-extended shiftOperand[11:0].
- Otherwise: Val_Rm shifted by shiftOperand[11:7], with shiftOperand[6:5] selecting 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-006 SHALL compute single-cycle results combinationally:
- MOV=Val2, MVN=~Val2.
- ADD=Val_Rn+Val2, ADC adds C.
- SUB=Val_Rn-Val2, SBC=Val_Rn-Val2-!C.
- AND, ORR, EOR bitwise.
REQ-007 SHALL derive flags as follows:
- N=result[31], Z=(result==0).
- C = carry-out for ADD/ADC; no-borrow for SUB/SBC.
- V = signed overflow for add/sub.
- Logical and move commands leave C and V unchanged.
REQ-008 SHALL set Br_Addr = PC + (sign-extended Imm24 << 2), modulo 2^32.
REQ-009 SHALL load the status register on a rising edge only when S=1 and stall=0.
REQ-010 SHALL implement MUL with a three-state FSM: IDLE, BUSY, DONE.
REQ-011 IDLE: when EXE_CMD=MUL, SHALL assert stall combinationally; at the edge, capture Val_Rn and Val2, clear the accumulator and counter, and go to BUSY.
REQ-012 BUSY: SHALL perform one shift-add step per cycle with stall=1; after 32 steps (counter 0..31) SHALL go to DONE.
REQ-013 DONE: SHALL drive stall=0 and ALU_Res = low 32 bits of the product; if S=1, SHALL update N,Z from the product and keep C,V; SHALL return to IDLE at the next edge.
REQ-014 SHALL keep MUL latency fixed: stall high for exactly 33 cycles, with the result valid in cycle 34; a back-to-back MUL restarts from IDLE.
REQ-015 SHALL ignore operand changes during BUSY; only the captured operands are used.
REQ-016 SHALL keep stall=0 for every non-MUL command.

Reset
REQ-017 On rst=1 at a rising edge, SHALL clear status to 0000, put the FSM in IDLE, and clear the counter and accumulator; a MUL in progress is abandoned.
REQ-018 After reset, stall SHALL equal 0 unless the present EXE_CMD is MUL.

Verification
REQ-019 The bench SHALL check ADD with S=1, Val_Rn=0x7FFFFFFF, I=1, shiftOperand=0x001 -> ALU_Res=0x80000000 and status 1001 after the edge.
REQ-020 The bench SHALL check SUB with S=1, Val_Rn=5, Val2=5 -> ALU_Res=0 and status 0110; the same with S=0 -> status unchanged.
REQ-021 The bench SHALL check the I=1 rotate: shiftOperand=0x2FF -> Val2=0xF000000F; MOV gives ALU_Res=0xF000000F.
REQ-022 The bench SHALL check the register shift: Val_Rm=0x80000000 with ASR by 4 -> 0xF8000000; ROR by 4 of 0x0000000F -> 0xF0000000.
REQ-023 The bench SHALL check MUL 7*-3 with S=1: stall high for 33 cycles, then ALU_Res=0xFFFFFFEB and N=1, Z=0 with C,V kept; stall low in the DONE cycle.
REQ-024 The bench SHALL check reset after cycle 10 of a MUL -> stall=0 with a non-MUL command, FSM in IDLE, status=0000; Br_Addr for PC=0x100, Imm24=0xFFFFFF -> 0x000000FC.
